// File: rtl/wb_flash_arbiter.sv
// Two-master Wishbone arbiter in front of the flash emulator: round-robin grant
// held for the owner's whole cycle, with a watchdog that errors unanswered strobes.
module wb_flash_arbiter #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk_i,
    input  logic        rst_ni,

    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    input  logic        m0_we_i,
    input  logic [31:0] m0_adr_i,
    input  logic [3:0]  m0_sel_i,
    input  logic [31:0] m0_dat_i,
    output logic [31:0] m0_dat_o,
    output logic        m0_ack_o,
    output logic        m0_err_o,
    output logic        m0_rty_o,

    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    input  logic        m1_we_i,
    input  logic [31:0] m1_adr_i,
    input  logic [3:0]  m1_sel_i,
    input  logic [31:0] m1_dat_i,
    output logic [31:0] m1_dat_o,
    output logic        m1_ack_o,
    output logic        m1_err_o,
    output logic        m1_rty_o,

    output logic        s_cyc_o,
    output logic        s_stb_o,
    output logic        s_we_o,
    output logic [31:0] s_adr_o,
    output logic [3:0]  s_sel_o,
    output logic [31:0] s_dat_o,
    input  logic [31:0] s_dat_i,
    input  logic        s_ack_i,
    input  logic        s_err_i,
    input  logic        s_rty_i,

    output logic [1:0]  grant_o
);

    localparam int unsigned CNT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);

    // One-hot encoding so the state doubles as the grant vector.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OWN0 = 2'b01,
        OWN1 = 2'b10
    } state_t;

    state_t             state_q, state_d;
    logic               last_q, last_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               owner_req;
    logic               slv_resp;
    logic               timeout_hit;

    assign owner_req = ((state_q == OWN0) && m0_cyc_i && m0_stb_i) ||
                       ((state_q == OWN1) && m1_cyc_i && m1_stb_i);
    assign slv_resp  = s_ack_i | s_err_i | s_rty_i;

    // A slave response in the limit cycle takes precedence over the watchdog.
    assign timeout_hit = (TIMEOUT != 32'd0) && owner_req && !slv_resp &&
                         (cnt_q == CNT_W'(TIMEOUT));

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state, last-owner and watchdog update
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cnt_d   = '0;

        case (state_q)
            IDLE: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    state_d = last_q ? OWN0 : OWN1;
                end else if (m0_cyc_i) begin
                    state_d = OWN0;
                end else if (m1_cyc_i) begin
                    state_d = OWN1;
                end
            end
            OWN0:    if (!m0_cyc_i) state_d = IDLE;
            OWN1:    if (!m1_cyc_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (state_q == IDLE && state_d == OWN0) last_d = 1'b0;
        if (state_q == IDLE && state_d == OWN1) last_d = 1'b1;

        if ((TIMEOUT != 32'd0) && (state_d == state_q) && owner_req &&
            !slv_resp && !timeout_hit) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Routing between the owner and the slave
    always_comb begin
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_we_o   = 1'b0;
        s_adr_o  = '0;
        s_sel_o  = '0;
        s_dat_o  = '0;
        m0_dat_o = '0;
        m0_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m0_rty_o = 1'b0;
        m1_dat_o = '0;
        m1_ack_o = 1'b0;
        m1_err_o = 1'b0;
        m1_rty_o = 1'b0;
        grant_o  = state_q;

        case (state_q)
            OWN0: begin
                s_cyc_o  = m0_cyc_i;
                s_stb_o  = m0_stb_i & ~timeout_hit;
                s_we_o   = m0_we_i;
                s_adr_o  = m0_adr_i;
                s_sel_o  = m0_sel_i;
                s_dat_o  = m0_dat_i;
                m0_dat_o = s_dat_i;
                m0_ack_o = s_ack_i;
                m0_err_o = s_err_i | timeout_hit;
                m0_rty_o = s_rty_i;
            end
            OWN1: begin
                s_cyc_o  = m1_cyc_i;
                s_stb_o  = m1_stb_i & ~timeout_hit;
                s_we_o   = m1_we_i;
                s_adr_o  = m1_adr_i;
                s_sel_o  = m1_sel_i;
                s_dat_o  = m1_dat_i;
                m1_dat_o = s_dat_i;
                m1_ack_o = s_ack_i;
                m1_err_o = s_err_i | timeout_hit;
                m1_rty_o = s_rty_i;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_wb_flash_arbiter.sv
// Directed bench for wb_flash_arbiter: the bench plays both masters and the slave,
// queuing expected read data when the slave answers and popping it at the master.
module tb_wb_flash_arbiter;

    logic        clk;
    logic        rst_n;
    logic        m0_cyc, m0_stb, m0_we;
    logic [31:0] m0_adr, m0_dat_w;
    logic [3:0]  m0_sel;
    logic [31:0] m0_dat_r;
    logic        m0_ack, m0_err, m0_rty;
    logic        m1_cyc, m1_stb, m1_we;
    logic [31:0] m1_adr, m1_dat_w;
    logic [3:0]  m1_sel;
    logic [31:0] m1_dat_r;
    logic        m1_ack, m1_err, m1_rty;
    logic        s_cyc, s_stb, s_we;
    logic [31:0] s_adr, s_dat_w;
    logic [3:0]  s_sel;
    logic [31:0] s_dat_r;
    logic        s_ack, s_err, s_rty;
    logic [1:0]  grant;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_q[$];

    wb_flash_arbiter #(.TIMEOUT(4)) dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .m0_cyc_i (m0_cyc),
        .m0_stb_i (m0_stb),
        .m0_we_i  (m0_we),
        .m0_adr_i (m0_adr),
        .m0_sel_i (m0_sel),
        .m0_dat_i (m0_dat_w),
        .m0_dat_o (m0_dat_r),
        .m0_ack_o (m0_ack),
        .m0_err_o (m0_err),
        .m0_rty_o (m0_rty),
        .m1_cyc_i (m1_cyc),
        .m1_stb_i (m1_stb),
        .m1_we_i  (m1_we),
        .m1_adr_i (m1_adr),
        .m1_sel_i (m1_sel),
        .m1_dat_i (m1_dat_w),
        .m1_dat_o (m1_dat_r),
        .m1_ack_o (m1_ack),
        .m1_err_o (m1_err),
        .m1_rty_o (m1_rty),
        .s_cyc_o  (s_cyc),
        .s_stb_o  (s_stb),
        .s_we_o   (s_we),
        .s_adr_o  (s_adr),
        .s_sel_o  (s_sel),
        .s_dat_o  (s_dat_w),
        .s_dat_i  (s_dat_r),
        .s_ack_i  (s_ack),
        .s_err_i  (s_err),
        .s_rty_i  (s_rty),
        .grant_o  (grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: observed no finish expected finish");
        $fatal(1, "bench time limit");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Owner saw an ack: its data must match the oldest queued slave response.
    task automatic chk_ack(input string tag, input logic ack, input logic [31:0] dat);
        logic [31:0] exp_dat;
        chk({tag, "_ack"}, 32'(ack), 32'd1);
        if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $error("FAIL %s_sb: observed empty queue expected entry", tag);
        end else begin
            exp_dat = exp_q.pop_front();
            chk({tag, "_dat"}, dat, exp_dat);
        end
    endtask

    task automatic slave_ack(input logic [31:0] dat);
        s_ack   = 1'b1;
        s_dat_r = dat;
        exp_q.push_back(dat);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_adr = '0; m0_sel = '0; m0_dat_w = '0;
        m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_adr = '0; m1_sel = '0; m1_dat_w = '0;
        s_dat_r = '0; s_ack = 0; s_err = 0; s_rty = 0;
    endtask

    task automatic do_reset();
        tick();
        rst_n = 1'b0;
        clear_inputs();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        logic [1:0] exp_g;
        logic       own_ack, oth_ack;
        logic [31:0] own_dat;

        rst_n = 1'b0;
        clear_inputs();
        #1;
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_s_cyc", 32'(s_cyc), 32'd0);
        chk("rst_m0_ack", 32'(m0_ack), 32'd0);
        chk("rst_m1_dat", m1_dat_r, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;

        // Single read by master 0
        tick();
        m0_cyc = 1; m0_stb = 1; m0_adr = 32'h0; m0_sel = 4'hF;
        settle(); chk("rd_c0_grant", 32'(grant), 32'd0);
        tick();
        settle(); chk("rd_c1_grant", 32'(grant), 32'b01);
        chk("rd_c1_s_stb", 32'(s_stb), 32'd1);
        chk("rd_c1_m1_dat", m1_dat_r, 32'd0);
        tick(); slave_ack(32'hDEADBEEF);
        settle(); chk_ack("rd_c2_m0", m0_ack, m0_dat_r);
        chk("rd_c2_m1_ack", 32'(m1_ack), 32'd0);
        chk("rd_c2_m1_dat", m1_dat_r, 32'd0);
        tick(); s_ack = 0; s_dat_r = '0; m0_cyc = 0; m0_stb = 0;
        settle(); chk("rd_c3_grant", 32'(grant), 32'b01);
        tick();
        settle(); chk("rd_c4_grant", 32'(grant), 32'd0);

        // Simultaneous request from reset: master 0 first
        do_reset();
        tick();
        m0_cyc = 1; m0_stb = 1; m0_adr = 32'h100;
        m1_cyc = 1; m1_stb = 1; m1_adr = 32'h200;
        settle(); chk("sim_c0_grant", 32'(grant), 32'd0);
        tick();
        settle(); chk("sim_c1_grant", 32'(grant), 32'b01);
        chk("sim_c1_s_adr", s_adr, 32'h100);
        tick(); slave_ack(32'h11111111);
        settle(); chk_ack("sim_c2_m0", m0_ack, m0_dat_r);
        chk("sim_c2_m1_ack", 32'(m1_ack), 32'd0);
        tick(); s_ack = 0; m0_cyc = 0; m0_stb = 0;
        settle(); chk("sim_c3_grant", 32'(grant), 32'b01);
        tick();
        settle(); chk("sim_c4_grant", 32'(grant), 32'd0);
        chk("sim_c4_s_cyc", 32'(s_cyc), 32'd0);
        tick();
        settle(); chk("sim_c5_grant", 32'(grant), 32'b10);
        chk("sim_c5_s_adr", s_adr, 32'h200);
        tick(); slave_ack(32'h22222222);
        settle(); chk_ack("sim_c6_m1", m1_ack, m1_dat_r);
        chk("sim_c6_m0_dat", m0_dat_r, 32'd0);
        tick(); s_ack = 0; m1_cyc = 0; m1_stb = 0;
        settle(); chk("sim_c7_grant", 32'(grant), 32'b10);
        tick();
        settle(); chk("sim_c8_grant", 32'(grant), 32'd0);

        // Fairness: both masters keep requesting, one read per tenure
        tick();
        m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
        for (int i = 0; i < 4; i++) begin
            exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
            tick(); slave_ack(32'hA000_0000 + 32'(i));
            settle();
            own_ack = (i % 2 == 0) ? m0_ack : m1_ack;
            oth_ack = (i % 2 == 0) ? m1_ack : m0_ack;
            own_dat = (i % 2 == 0) ? m0_dat_r : m1_dat_r;
            chk($sformatf("fair%0d_grant", i), 32'(grant), 32'(exp_g));
            chk_ack($sformatf("fair%0d_own", i), own_ack, own_dat);
            chk($sformatf("fair%0d_oth_ack", i), 32'(oth_ack), 32'd0);
            tick(); s_ack = 0;
            if (i == 3) begin
                m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0;
            end else if (i % 2 == 0) begin
                m0_cyc = 0; m0_stb = 0;
            end else begin
                m1_cyc = 0; m1_stb = 0;
            end
            settle(); chk($sformatf("fair%0d_hold", i), 32'(grant), 32'(exp_g));
            tick();
            if (i != 3) begin
                m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
            end
            settle(); chk($sformatf("fair%0d_idle", i), 32'(grant), 32'd0);
        end

        // Watchdog: slave never answers master 1
        do_reset();
        tick();
        m1_cyc = 1; m1_stb = 1; m1_adr = 32'h300;
        for (int c = 1; c <= 6; c++) begin
            tick();
            settle();
            chk($sformatf("wd_c%0d_err", c), 32'(m1_err), (c == 5) ? 32'd1 : 32'd0);
            chk($sformatf("wd_c%0d_s_stb", c), 32'(s_stb), (c == 5) ? 32'd0 : 32'd1);
            chk($sformatf("wd_c%0d_ack", c), 32'(m1_ack), 32'd0);
            chk($sformatf("wd_c%0d_grant", c), 32'(grant), 32'b10);
        end
        tick(); m1_cyc = 0; m1_stb = 0;
        settle(); chk("wd_c7_grant", 32'(grant), 32'b10);
        tick();
        settle(); chk("wd_c8_grant", 32'(grant), 32'd0);

        // Slave answers exactly at the watchdog limit
        do_reset();
        tick();
        m1_cyc = 1; m1_stb = 1; m1_adr = 32'h400;
        for (int c = 1; c <= 4; c++) tick();
        settle(); chk("lim_c4_err", 32'(m1_err), 32'd0);
        tick(); slave_ack(32'h55AA55AA);
        settle(); chk_ack("lim_c5_m1", m1_ack, m1_dat_r);
        chk("lim_c5_err", 32'(m1_err), 32'd0);
        tick(); s_ack = 0; m1_cyc = 0; m1_stb = 0;
        tick();

        // Reset in the middle of a master 0 read
        do_reset();
        tick();
        m0_cyc = 1; m0_stb = 1; m0_adr = 32'h500;
        tick();
        settle(); chk("mid_c1_grant", 32'(grant), 32'b01);
        tick(); s_ack = 1; s_dat_r = 32'hCAFEF00D;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_grant", 32'(grant), 32'd0);
        chk("mid_rst_s_cyc", 32'(s_cyc), 32'd0);
        chk("mid_rst_s_stb", 32'(s_stb), 32'd0);
        chk("mid_rst_m0_ack", 32'(m0_ack), 32'd0);
        clear_inputs();
        tick();
        rst_n = 1'b1;
        m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
        tick();
        settle(); chk("mid_tie_grant", 32'(grant), 32'b01);
        tick(); clear_inputs();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
